// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
// Holds the FSM state encoding and the slice width.
package adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/CLA_four_bit.sv
// 4-bit carry-lookahead adder slice.
// Purely combinational; all four carries are computed from generate/propagate terms.
module CLA_four_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl_dp.sv
// Datapath for the nibble-serial adder: latched operands, inter-nibble carry,
// result/flag registers, and the single shared CLA slice.
module nibble_serial_adder_ctrl_dp
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             last,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                carry_q, carry_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (int'(idx) == n) begin
        a_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  CLA_four_bit u_cla (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  // b_q holds the effective operand: already inverted for subtraction.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (load) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
    end else if (step) begin
      carry_d = nib_cout;
      for (int n = 0; n < NIB; n++) begin
        if (int'(idx) == n) begin
          sum_d[n*NIBBLE_W +: NIBBLE_W] = nib_sum;
        end
      end
      if (last) begin
        cout_d = nib_cout;
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced over one 4-bit CLA slice, LSB nibble first.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one nibble per cycle, index counts 0..NIB-1
//   DONE  | result held on out_valid until out_ready
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             load;
  logic             step;
  logic             last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        last = (idx_q == IDX_W'(NIB - 1));
        // Park the index at 0 after the last nibble so it never wraps.
        if (last) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  nibble_serial_adder_ctrl_dp #(
    .WIDTH (WIDTH),
    .NIB   (NIB),
    .IDX_W (IDX_W)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .last     (last),
    .idx      (idx_q),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// Expected results come from a plain-arithmetic model of add/subtract.
module tb_nibble_serial_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Returns {overflow, cout, sum} from integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    int unsigned ua, ub, raw;
    int          sa, sb, exact;
    logic        c_out, ovf;
    logic [W-1:0] s;
    ua = ma;
    ub = mb;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (ms) begin
      raw   = ua - ub;
      c_out = (ua >= ub);
      exact = sa - sb;
    end else begin
      raw   = ua + ub + mc;
      c_out = (ua + ub + mc) >= 65536;
      exact = sa + sb + int'(mc);
    end
    s   = raw[W-1:0];
    ovf = (exact > 32767) || (exact < -32768);
    return {ovf, c_out, s};
  endfunction

  // Present one operation, then wait (bounded) for out_valid.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input logic ts, output int lat, output int rdy_bad);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    rdy_bad = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) rdy_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_status got in_ready/busy/out_valid=%b expected 100", {in_ready, busy, out_valid});
    end
    checks++;
    if ({overflow, cout, sum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b expected zeros", sum, cout, overflow);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h00FF, 16'h0005, 16'h8000};
    logic [W-1:0] vb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
    logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         vs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] es [6] = '{16'h5555, 16'h0000, 16'h8000, 16'h0100, 16'hFFFE, 16'h7FFF};
    logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat, rb;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vc[i], vs[i], lat, rb);
      checks++;
      if (lat !== NIB) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d cycles expected %0d", i, lat, NIB);
      end
      checks++;
      if (rb !== 0) begin
        errors++;
        $display("FAIL dir%0d_in_ready_in_run got %0d high cycles expected 0", i, rb);
      end
      checks++;
      if ({overflow, cout, sum} !== {eo[i], ec[i], es[i]}) begin
        errors++;
        $display("FAIL dir%0d_result got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, sum, cout, overflow, es[i], ec[i], eo[i]);
      end
      drain();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL dir%0d_return_idle got in_ready/out_valid=%b expected 10", i, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rbv;
    logic         rc, rs;
    logic [W+1:0] exp;
    int lat, rb;
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom); rbv = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 5 == 0) rbv = ra;
      exp = model(ra, rbv, rc, rs);
      issue(ra, rbv, rc, rs, lat, rb);
      checks++;
      if (lat !== NIB || rb !== 0) begin
        errors++;
        $display("FAIL rnd%0d_timing got latency=%0d in_ready_high=%0d expected %0d/0", i, lat, rb, NIB);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if ({overflow, cout, sum} !== exp) begin
        errors++;
        $display("FAIL rnd%0d_result a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, ra, rbv, rc, rs, sum, cout, overflow, exp[W-1:0], exp[W], exp[W+1]);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp;
    logic [W-1:0] na, nb;
    int lat, rb;
    exp = model(16'h3A5C, 16'h7123, 1'b1, 1'b0);
    issue(16'h3A5C, 16'h7123, 1'b1, 1'b0, lat, rb);
    for (int s = 0; s < 5; s++) begin
      if (s == 2) begin
        in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0; sub = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101 || {overflow, cout, sum} !== exp) begin
        errors++;
        $display("FAIL stall%0d got out_valid/in_ready/busy=%b sum=%h cout=%b ovf=%b expected 101 sum=%h cout=%b ovf=%b",
                 s, {out_valid, in_ready, busy}, sum, cout, overflow, exp[W-1:0], exp[W], exp[W+1]);
      end
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL stall_release got in_ready/out_valid=%b expected 10", {in_ready, out_valid});
    end
    na = 16'h0F0F; nb = 16'h1111;
    exp = model(na, nb, 1'b0, 1'b1);
    issue(na, nb, 1'b0, 1'b1, lat, rb);
    checks++;
    if (lat !== NIB || {overflow, cout, sum} !== exp) begin
      errors++;
      $display("FAIL stall_next_op got latency=%0d sum=%h cout=%b ovf=%b expected %0d sum=%h cout=%b ovf=%b",
               lat, sum, cout, overflow, NIB, exp[W-1:0], exp[W], exp[W+1]);
    end
    drain();
  endtask

  task automatic test_reset_mid_run();
    int lat, rb;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || {overflow, cout, sum} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got in_ready/busy/out_valid=%b sum=%h cout=%b ovf=%b expected 100 and zeros",
               {in_ready, busy, out_valid}, sum, cout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, lat, rb);
    checks++;
    if (lat !== NIB || {overflow, cout, sum} !== {2'b00, 16'h0002}) begin
      errors++;
      $display("FAIL midrun_after got latency=%0d sum=%h cout=%b ovf=%b expected %0d sum=0002 cout=0 ovf=0",
               lat, sum, cout, overflow, NIB);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] expq [$];
    logic [W+1:0] e;
    int last_acc = -1;
    int accepts = 0;
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : '0;
        checks++;
        if ({overflow, cout, sum} !== e) begin
          errors++;
          $display("FAIL b2b_result got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   sum, cout, overflow, e[W-1:0], e[W], e[W+1]);
        end
      end
      if (in_ready) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== NIB + 2) begin
            errors++;
            $display("FAIL b2b_interval got %0d cycles expected %0d", cyc - last_acc, NIB + 2);
          end
        end
        last_acc = cyc;
        accepts++;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        expq.push_back(model(a, b, cin, sub));
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && expq.size() > 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = expq.pop_front();
        checks++;
        if ({overflow, cout, sum} !== e) begin
          errors++;
          $display("FAIL b2b_tail_result got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   sum, cout, overflow, e[W-1:0], e[W], e[W+1]);
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (expq.size() !== 0 || accepts < 5) begin
      errors++;
      $display("FAIL b2b_drain got %0d pending results and %0d accepts expected 0 pending and at least 5",
               expq.size(), accepts);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit carry-lookahead slice over WIDTH/4 nibbles, LSB nibble first. A registered carry links consecutive nibbles. Valid/ready handshakes on both the operand side and the result side. Used where area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NIB, derived = WIDTH/4, number of nibble iterations (localparam, not overridable)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in, add mode only
sub  input  1  1 = compute A - B (B inverted, carry-in forced 1, cin ignored)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry-out (sub mode: 1 = no borrow)
overflow  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, nibble index=0, carry reg=0, sum=0, cout=0, overflow=0, out_valid=0. All are cleared immediately on assertion, including mid-RUN or mid-DONE. The in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE). busy = (state!=IDLE). out_valid = (state==DONE).
- IDLE: on an edge with in_valid && in_ready, latch a, b_eff = sub ? ~b : b, and carry = sub ? 1 : cin. Clear the index to 0. Go to RUN. Otherwise remain in IDLE.
- RUN, one nibble per cycle, at index i:
  - The slice computes a[4i+3:4i] + b_eff[4i+3:4i] + carry.
  - Write the 4-bit result into sum[4i+3:4i]. carry <= slice Cout. i <= i+1.
  - When i==NIB-1: latch cout from the slice Cout. Set overflow = (a[WIDTH-1]==b_eff[WIDTH-1]) && (new sum MSB != a[WIDTH-1]). Go to DONE.
  - in_valid is ignored in RUN; latched operands are unaffected by input changes.
- Latency: with the accept at edge k, out_valid is high after edge k+NIB. WIDTH=16 gives 4 cycles.
- DONE: sum, cout and overflow are held stable while out_valid && !out_ready, with no limit on stall length. On an edge with out_ready, go to IDLE. There is no same-cycle re-accept; minimum issue interval is NIB+2 cycles.
- The sum register is overwritten nibble by nibble during RUN and is meaningful only while out_valid=1.
- Index counter width is $clog2(NIB) with a minimum of 1. NIB=1 (WIDTH=4): a single RUN cycle, and index wrap never occurs.
- Signals out of range are never produced. No X propagation from unaccepted inputs.

Decomposition:
- Package adder_ctrl_pkg:
  - state enum (IDLE, RUN, DONE), 2-bit encoding
  - constant NIBBLE_W=4
- One sub-module: instantiate the team's existing 4-bit CLA slice CLA_four_bit once. The operand nibble mux and the carry/sum registers live in this block.

Test Plan:
- WIDTH=16, add: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, overflow=0. out_valid rises exactly 4 cycles after the accept; in_ready=0 throughout.
- add: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. This checks carry ripple across all 4 nibble iterations.
- add: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1. Also a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0.
- sub: a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, overflow=0. Also a=0x8000, b=0x0001 -> sum=0x7FFF, overflow=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum/cout/overflow are stable, in_ready=0. Pulse in_valid with new operands during the stall -> they are not accepted. Raise out_ready -> IDLE on the next edge, then the next op is accepted.
- Reset mid-RUN: pull rst_n low during nibble 2 -> outputs go to 0 immediately, state=IDLE. After release, a=0x0001, b=0x0001 -> sum=0x0002, with no residue from the aborted op.
